// File: rtl/nx_ram_arb_pkg.sv
// Shared types for the 1R1W RAM hardware-port arbiter.
// Tag layout, yield FSM states and latency helper.
package nx_ram_arb_pkg;

    localparam int ID_MAX_W = 3;

    typedef enum logic {
        RUN   = 1'b0,
        YIELD = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                vld;
        logic [ID_MAX_W-1:0] id;
    } rsp_tag_t;

    function automatic int lat_sum(
        input int in_flop,
        input int out_flop,
        input int rd_lat
    );
        return in_flop + out_flop + rd_lat;
    endfunction

endpackage

// File: rtl/nx_ram_1r1w_hw_arb_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping.
// Pure combinational; one-hot grant plus encoded index.
module nx_rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr) + k) % N);
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/nx_ram_1r1w_hw_arb.sv
// Arbitrates N_REQ clients onto the wrapper hardware port, yields
// to software on request and routes tagged read data back.
module nx_ram_1r1w_hw_arb
    import nx_ram_arb_pkg::*;
#(
    parameter  int N_REQ       = 4,
    parameter  int N_ENTRIES   = 1024,
    parameter  int N_DATA_BITS = 32,
    parameter  int IN_FLOP     = 0,
    parameter  int OUT_FLOP    = 0,
    parameter  int RD_LATENCY  = 1,
    parameter  int MAX_HOLD    = 16,
    localparam int AW          = $clog2(N_ENTRIES),
    localparam int IW          = $clog2(N_REQ),
    localparam int DW          = N_DATA_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    rd_req,
    input  logic [N_REQ*AW-1:0] rd_addr,
    output logic [N_REQ-1:0]    rd_gnt,
    input  logic [N_REQ-1:0]    wr_req,
    input  logic [N_REQ*AW-1:0] wr_addr,
    input  logic [N_REQ*DW-1:0] wr_dat,
    output logic [N_REQ-1:0]    wr_gnt,
    output logic                rsp_vld,
    output logic [IW-1:0]       rsp_id,
    output logic [DW-1:0]       rsp_dat,
    output logic                hw_cs,
    output logic                hw_we,
    output logic                hw_re,
    output logic [AW-1:0]       hw_raddr,
    output logic [AW-1:0]       hw_waddr,
    output logic [DW-1:0]       hw_din,
    input  logic [DW-1:0]       hw_dout,
    input  logic                hw_yield
);

    localparam int LAT = lat_sum(IN_FLOP, OUT_FLOP, RD_LATENCY);
    localparam int HW  = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_e      state;
    logic [HW-1:0]   hold_cnt;
    logic [IW-1:0]   rd_ptr, wr_ptr;
    logic [N_REQ-1:0] rd_pick, wr_pick;
    logic [IW-1:0]   rd_idx, wr_idx;
    logic            rd_any, wr_any;
    logic [AW-1:0]   rd_win_addr, wr_win_addr;
    logic [DW-1:0]   wr_win_dat;
    logic            run, hazard, rd_go, wr_go;
    rsp_tag_t        tag_pipe [LAT];
    rsp_tag_t        tag_out;
    logic            unused_id;

    nx_rr_pick #(.N(N_REQ)) u_rd_pick (
        .req (rd_req),
        .ptr (rd_ptr),
        .gnt (rd_pick),
        .idx (rd_idx),
        .any (rd_any)
    );

    nx_rr_pick #(.N(N_REQ)) u_wr_pick (
        .req (wr_req),
        .ptr (wr_ptr),
        .gnt (wr_pick),
        .idx (wr_idx),
        .any (wr_any)
    );

    assign rd_win_addr = rd_addr[rd_idx*AW +: AW];
    assign wr_win_addr = wr_addr[wr_idx*AW +: AW];
    assign wr_win_dat  = wr_dat[wr_idx*DW +: DW];

    // Same-address collision: write first so the later read sees new data.
    assign run    = rst_n && (state == RUN);
    assign hazard = rd_any && wr_any && (rd_win_addr == wr_win_addr);
    assign wr_go  = run && wr_any;
    assign rd_go  = run && rd_any && !hazard;

    assign wr_gnt   = wr_go ? wr_pick : '0;
    assign rd_gnt   = rd_go ? rd_pick : '0;
    assign hw_we    = wr_go;
    assign hw_re    = rd_go;
    assign hw_cs    = wr_go | rd_go;
    assign hw_waddr = wr_go ? wr_win_addr : '0;
    assign hw_din   = wr_go ? wr_win_dat : '0;
    assign hw_raddr = rd_go ? rd_win_addr : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (rd_go) rd_ptr <= IW'((int'(rd_idx) + 1) % N_REQ);
            if (wr_go) wr_ptr <= IW'((int'(wr_idx) + 1) % N_REQ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            hold_cnt <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (hw_cs && hw_yield) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state    <= YIELD;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end else begin
                        hold_cnt <= '0;
                    end
                end
                YIELD: begin
                    state    <= RUN;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0].vld <= rd_go;
            tag_pipe[0].id  <= rd_go ? ID_MAX_W'(rd_idx) : '0;
            for (int i = 1; i < LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign tag_out   = tag_pipe[LAT-1];
    assign rsp_vld   = tag_out.vld;
    assign rsp_id    = tag_out.id[IW-1:0];
    assign rsp_dat   = hw_dout;
    assign unused_id = ^tag_out.id;

endmodule

// File: tb/tb_nx_ram_1r1w_hw_arb.sv
// Directed bench for nx_ram_1r1w_hw_arb with a behavioural RAM model.
// A second instance with read latency 3 covers reset mid-flight.
module tb_nx_ram_1r1w_hw_arb;
    import nx_ram_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n, rst3_n;
    logic [N-1:0]  rd_req, wr_req, rd_req3;
    logic [N*AW-1:0] rd_addr, wr_addr;
    logic [N*DW-1:0] wr_dat;
    logic [N-1:0]  rd_gnt, wr_gnt;
    logic          rsp_vld;
    logic [1:0]    rsp_id;
    logic [DW-1:0] rsp_dat;
    logic          hw_cs, hw_we, hw_re, hw_yield;
    logic [AW-1:0] hw_raddr, hw_waddr;
    logic [DW-1:0] hw_din;
    logic [DW-1:0] hw_dout = '0;

    logic [N-1:0]  rd_gnt3, unused_wr_gnt3;
    logic          rsp_vld3;
    logic [1:0]    rsp_id3;
    logic [DW-1:0] unused_rsp_dat3, unused_din3;
    logic          unused_cs3, unused_we3, unused_re3;
    logic [AW-1:0] unused_raddr3, unused_waddr3;

    logic [DW-1:0] mem [1024];
    bit            written [1024];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    nx_ram_1r1w_hw_arb u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_gnt   (rd_gnt),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_dat   (wr_dat),
        .wr_gnt   (wr_gnt),
        .rsp_vld  (rsp_vld),
        .rsp_id   (rsp_id),
        .rsp_dat  (rsp_dat),
        .hw_cs    (hw_cs),
        .hw_we    (hw_we),
        .hw_re    (hw_re),
        .hw_raddr (hw_raddr),
        .hw_waddr (hw_waddr),
        .hw_din   (hw_din),
        .hw_dout  (hw_dout),
        .hw_yield (hw_yield)
    );

    nx_ram_1r1w_hw_arb #(.RD_LATENCY(3)) u_dut3 (
        .clk      (clk),
        .rst_n    (rst3_n),
        .rd_req   (rd_req3),
        .rd_addr  (rd_addr),
        .rd_gnt   (rd_gnt3),
        .wr_req   (4'b0000),
        .wr_addr  (wr_addr),
        .wr_dat   (wr_dat),
        .wr_gnt   (unused_wr_gnt3),
        .rsp_vld  (rsp_vld3),
        .rsp_id   (rsp_id3),
        .rsp_dat  (unused_rsp_dat3),
        .hw_cs    (unused_cs3),
        .hw_we    (unused_we3),
        .hw_re    (unused_re3),
        .hw_raddr (unused_raddr3),
        .hw_waddr (unused_waddr3),
        .hw_din   (unused_din3),
        .hw_dout  (32'h0),
        .hw_yield (1'b0)
    );

    // Wrapper model, latency 1; unwritten words read back as D000_0000|addr.
    always @(posedge clk) begin
        if (hw_we) begin
            mem[hw_waddr]     <= hw_din;
            written[hw_waddr] <= 1'b1;
        end
        if (hw_re)
            hw_dout <= written[hw_raddr] ? mem[hw_raddr]
                                         : (32'hD000_0000 | 32'(hw_raddr));
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst_n    = 1'b0;
        rst3_n   = 1'b0;
        rd_req   = 4'hF;
        wr_req   = '0;
        rd_req3  = '0;
        rd_addr  = '0;
        wr_addr  = '0;
        wr_dat   = '0;
        hw_yield = 1'b0;

        // Reset: requests present but nothing may be granted
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rd_gnt", 64'(rd_gnt), 64'h0);
        chk("rst_hw_cs", 64'(hw_cs), 64'h0);
        chk("rst_hw_re", 64'(hw_re), 64'h0);
        chk("rst_rsp_vld", 64'(rsp_vld), 64'h0);
        chk("rst_rsp_id", 64'(rsp_id), 64'h0);
        rd_req = '0;
        @(negedge clk);
        rst_n  = 1'b1;
        rst3_n = 1'b1;

        // Round robin with all four readers
        rd_addr[0*AW +: AW] = 10'h020;
        rd_addr[1*AW +: AW] = 10'h021;
        rd_addr[2*AW +: AW] = 10'h022;
        rd_addr[3*AW +: AW] = 10'h023;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rd_req = 4'hF;
            #1;
            chk("rr_gnt", 64'(rd_gnt), 64'(4'b0001 << (k % 4)));
            chk("rr_raddr", 64'(hw_raddr), 64'(32'h20 + (k % 4)));
            if (k == 0) begin
                chk("rr_vld0", 64'(rsp_vld), 64'h0);
            end else begin
                chk("rr_vld", 64'(rsp_vld), 64'h1);
                chk("rr_id", 64'(rsp_id), 64'((k - 1) % 4));
                chk("rr_dat", 64'(rsp_dat),
                    64'(32'hD000_0020 + ((k - 1) % 4)));
            end
        end
        @(negedge clk);
        rd_req = '0;
        #1;
        chk("rr_tail_vld", 64'(rsp_vld), 64'h1);
        chk("rr_tail_id", 64'(rsp_id), 64'h0);
        chk("rr_tail_dat", 64'(rsp_dat), 64'hD000_0020);

        // Same-address hazard: client 1 writes, client 2 reads 0x10
        @(negedge clk);
        wr_addr[1*AW +: AW] = 10'h010;
        wr_dat[1*DW +: DW]  = 32'hA5A5_0001;
        rd_addr[2*AW +: AW] = 10'h010;
        wr_req = 4'b0010;
        rd_req = 4'b0100;
        #1;
        chk("hz_wr_gnt", 64'(wr_gnt), 64'h2);
        chk("hz_rd_gnt", 64'(rd_gnt), 64'h0);
        chk("hz_we", 64'(hw_we), 64'h1);
        chk("hz_re", 64'(hw_re), 64'h0);
        chk("hz_waddr", 64'(hw_waddr), 64'h10);
        chk("hz_din", 64'(hw_din), 64'hA5A5_0001);
        @(negedge clk);
        wr_req = '0;
        #1;
        chk("hz_rd_gnt2", 64'(rd_gnt), 64'h4);
        chk("hz_raddr2", 64'(hw_raddr), 64'h10);
        @(negedge clk);
        rd_req = '0;
        #1;
        chk("hz_rsp_vld", 64'(rsp_vld), 64'h1);
        chk("hz_rsp_id", 64'(rsp_id), 64'h2);
        chk("hz_rsp_dat", 64'(rsp_dat), 64'hA5A5_0001);

        // Concurrent read (client 3, addr 5) and write (client 0, addr 7)
        @(negedge clk);
        rd_addr[3*AW +: AW] = 10'h005;
        wr_addr[0*AW +: AW] = 10'h007;
        wr_dat[0*DW +: DW]  = 32'h1234_5678;
        rd_req = 4'b1000;
        wr_req = 4'b0001;
        #1;
        chk("cc_rd_gnt", 64'(rd_gnt), 64'h8);
        chk("cc_wr_gnt", 64'(wr_gnt), 64'h1);
        chk("cc_we", 64'(hw_we), 64'h1);
        chk("cc_re", 64'(hw_re), 64'h1);
        chk("cc_cs", 64'(hw_cs), 64'h1);
        chk("cc_raddr", 64'(hw_raddr), 64'h5);
        chk("cc_waddr", 64'(hw_waddr), 64'h7);
        @(negedge clk);
        rd_req = '0;
        wr_req = '0;
        #1;
        chk("cc_rsp_id", 64'(rsp_id), 64'h3);
        chk("cc_rsp_dat", 64'(rsp_dat), 64'hD000_0005);

        // Idle clients with yield pending: nothing happens
        hw_yield = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            chk("idle_cs", 64'(hw_cs), 64'h0);
        end
        chk("idle_state", 64'(u_dut.state), 64'(RUN));
        chk("idle_hold", 64'(u_dut.hold_cnt), 64'h0);

        // Client 0 streaming under yield: 16 on, 1 off, repeating
        rd_addr[0*AW +: AW] = 10'h030;
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            rd_req = 4'b0001;
            #1;
            chk("yield_cs", 64'(hw_cs),
                (k == 16 || k == 33) ? 64'h0 : 64'h1);
        end
        @(negedge clk);
        rd_req   = '0;
        hw_yield = 1'b0;

        // Latency-3 instance: three reads, then reset mid-flight
        @(negedge clk);
        rd_req3 = 4'b0100;
        #1;
        chk("l3_gnt_a", 64'(rd_gnt3), 64'h4);
        chk("l3_vld_a", 64'(rsp_vld3), 64'h0);
        @(negedge clk);
        rd_req3 = 4'b1000;
        #1;
        chk("l3_gnt_b", 64'(rd_gnt3), 64'h8);
        @(negedge clk);
        rd_req3 = 4'b0001;
        #1;
        chk("l3_gnt_c", 64'(rd_gnt3), 64'h1);
        chk("l3_vld_c", 64'(rsp_vld3), 64'h0);
        @(negedge clk);
        rd_req3 = '0;
        #1;
        chk("l3_vld_first", 64'(rsp_vld3), 64'h1);
        chk("l3_id_first", 64'(rsp_id3), 64'h2);
        rst3_n = 1'b0;
        #1;
        chk("l3_vld_rst", 64'(rsp_vld3), 64'h0);
        @(negedge clk);
        rst3_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("l3_vld_after", 64'(rsp_vld3), 64'h0);
        end
        @(negedge clk);
        rd_req3 = 4'b1001;
        #1;
        chk("l3_post_gnt", 64'(rd_gnt3), 64'h1);
        @(negedge clk);
        rd_req3 = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("l3_post_vld", 64'(rsp_vld3), 64'h1);
        chk("l3_post_id", 64'(rsp_id3), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/nx_ram_1r1w_hw_arb.md
Name: nx_ram_1r1w_hw_arb

Overview:
- Shares the hardware port of a 1R1W indirect-access RAM wrapper among N_REQ hardware clients.
- Separate round-robin arbitration for the read channel and the write channel; at most one read and one write issue per cycle.
- Yields the port to software (hw_cs low for one cycle) when the wrapper's hw_yield is asserted, bounded by MAX_HOLD.
- Tags reads and returns read data to the issuing client after the wrapper's fixed read latency.

Parameters:
- N_REQ, 4, number of client channels (2..8).
- N_ENTRIES, 1024, RAM depth; address width is clog2(N_ENTRIES).
- N_DATA_BITS, 32, RAM data width.
- IN_FLOP, 0, must match the wrapper's IN_FLOP.
- OUT_FLOP, 0, must match the wrapper's OUT_FLOP.
- RD_LATENCY, 1, must match the wrapper's RD_LATENCY.
- MAX_HOLD, 16, maximum consecutive hw_cs cycles while hw_yield=1 (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active low.
- rd_req  in  N_REQ  per-client read request, level; held until granted.
- rd_addr  in  N_REQ*AW  packed read addresses; client i occupies [i*AW +: AW].
- rd_gnt  out  N_REQ  one-hot read grant, combinational, same cycle.
- wr_req  in  N_REQ  per-client write request, level; held until granted.
- wr_addr  in  N_REQ*AW  packed write addresses.
- wr_dat  in  N_REQ*N_DATA_BITS  packed write data.
- wr_gnt  out  N_REQ  one-hot write grant, combinational.
- rsp_vld  out  1  read data valid.
- rsp_id  out  clog2(N_REQ)  client index for rsp_dat.
- rsp_dat  out  N_DATA_BITS  read data (hw_dout passthrough).
- hw_cs, hw_we, hw_re  out  1 each  to the wrapper.
- hw_raddr, hw_waddr  out  AW each  to the wrapper.
- hw_din  out  N_DATA_BITS  to the wrapper.
- hw_dout  in  N_DATA_BITS  from the wrapper.
- hw_yield  in  1  from the wrapper: a software command is waiting.

Behaviour:
- Reset values: rd_ptr=0, wr_ptr=0, hold_cnt=0, state=RUN, tag pipe cleared.
- Outputs during reset: rsp_vld=0, rsp_id=0, all grants 0, hw_cs/hw_we/hw_re=0.
- LAT = IN_FLOP+OUT_FLOP+RD_LATENCY.

Arbitration:
- Read winner: first requesting client at or after rd_ptr, wrapping.
- Write winner: same rule using wr_ptr.
- On a grant to client i, the corresponding pointer becomes (i+1) mod N_REQ on the next clk. A pointer does not move without a grant.

RAM drive:
- hw_we = write granted; hw_re = read granted; hw_cs = hw_we | hw_re.
- hw_raddr, hw_waddr and hw_din are the winners' fields. They are 0 when the matching grant is 0.

Hazard rule:
- If the read and write winners target the same address in the same cycle, the write is granted and the read is withheld.
- rd_gnt=0 in that cycle and rd_ptr is held; the read issues in a later cycle and sees the new data.

Yield FSM:
- States are RUN and YIELD.
- hold_cnt increments in each cycle where hw_cs=1 and hw_yield=1. It clears when hw_cs=0 or hw_yield=0.
- RUN to YIELD when hw_yield=1 and hold_cnt==MAX_HOLD-1 while hw_cs=1 in the current cycle.
- YIELD lasts exactly one cycle: no grants, hw_cs=0, hold_cnt cleared. It then returns to RUN.
- If the clients are idle (hw_cs=0), software gets the port naturally; no FSM action is needed.
- hw_yield deasserting while in YIELD does not shorten or cancel the YIELD cycle.

Response path:
- A LAT-deep shift register carries {vld, id} for each issued read.
- rsp_vld/rsp_id are the pipe output. rsp_dat = hw_dout, valid only when rsp_vld=1.
- A read granted at cycle t gives rsp_vld=1 at cycle t+LAT. Back-to-back reads give back-to-back responses.

Reset mid-operation: in-flight tags are discarded and no rsp_vld is produced for them. Clients re-request after reset.

Width/limits:
- The tag pipe holds at most LAT outstanding reads; there is no backpressure on responses.
- Clients must sink rsp_vld in the same cycle.

Decomposition:
- Package nx_ram_arb_pkg:
  - arb_state_e {RUN, YIELD};
  - rsp_tag_t struct {vld, id};
  - localparam function for the latency sum.
- Sub-module nx_rr_pick (request vector and pointer in; one-hot grant and index out). Instantiated twice, once for read and once for write.

Test Plan:
- All 4 clients assert rd_req continuously, LAT=1 -> rd_gnt order 0,1,2,3,0; each rsp_id equals the granted id one cycle later; rsp_dat matches preloaded data.
- Client 1 write addr 0x10 data 0xA5A5_0001 and client 2 read addr 0x10 in the same cycle -> wr_gnt=0010, rd_gnt=0000; read granted next cycle; rsp_dat=0xA5A5_0001.
- hw_yield=1 with client 0 streaming reads, MAX_HOLD=16 -> hw_cs high 16 cycles, low exactly 1 cycle, then resumes; the pattern repeats while hw_yield stays high.
- Concurrent read by client 3 (addr 5) and write by client 0 (addr 7) -> both granted in one cycle: hw_we=1, hw_re=1, hw_raddr=5, hw_waddr=7.
- LAT=3 with 3 back-to-back reads, then rst_n pulsed low 1 cycle after the last grant -> no rsp_vld after reset; rd_ptr=0; the first post-reset grant goes to the lowest requesting index.
- No requests and hw_yield=1 -> hw_cs=0 throughout, state stays RUN, hold_cnt=0.
